// File: rtl/cond_if.sv
// Decode/execute control bundle for cond_unit; the flag save/restore strobes
// are present only when COND_FLAG_SAVE_EN is defined.
interface cond_if;
    logic       d_valid;
    logic [3:0] d_cond;
    logic [1:0] d_flagw;
    logic       d_pcs;
    logic       d_regw;
    logic       d_memw;
    logic       d_nowrite;
    logic       stall;
    logic       flush;
    logic [3:0] alu_flags;
`ifdef COND_FLAG_SAVE_EN
    logic       flag_save;
    logic       flag_restore;
`endif
    logic [3:0] flags;
    logic       cond_ex;
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       e_valid;

    modport master (
        output d_valid, d_cond, d_flagw, d_pcs, d_regw, d_memw, d_nowrite,
        output stall, flush, alu_flags,
`ifdef COND_FLAG_SAVE_EN
        output flag_save, flag_restore,
`endif
        input  flags, cond_ex, pcsrc, regwrite, memwrite, e_valid
    );

    modport slave (
        input  d_valid, d_cond, d_flagw, d_pcs, d_regw, d_memw, d_nowrite,
        input  stall, flush, alu_flags,
`ifdef COND_FLAG_SAVE_EN
        input  flag_save, flag_restore,
`endif
        output flags, cond_ex, pcsrc, regwrite, memwrite, e_valid
    );
endinterface

// File: rtl/cond_unit.sv
// Execute-stage condition unit: owns the NZCV register, gates side effects.
// Optional flag shadow register enabled by defining COND_FLAG_SAVE_EN.
module cond_unit #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input logic   clk,
    input logic   reset,
    cond_if.slave bus
);

    logic       vld_p1;
    logic [3:0] cond_p1;
    logic [1:0] flagw_p1;
    logic       pcs_p1;
    logic       regw_p1;
    logic       memw_p1;
    logic       nowrite_p1;

    logic [3:0] flags_q;
    logic [3:0] flags_next;
    logic       pass;
    logic       cond_ex;
    logic       flag_we;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

    // Decode -> execute stage boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1     <= 1'b0;
            cond_p1    <= 4'b0000;
            flagw_p1   <= 2'b00;
            pcs_p1     <= 1'b0;
            regw_p1    <= 1'b0;
            memw_p1    <= 1'b0;
            nowrite_p1 <= 1'b0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (!bus.stall) begin
            vld_p1     <= bus.d_valid;
            cond_p1    <= bus.d_cond;
            flagw_p1   <= bus.d_flagw;
            pcs_p1     <= bus.d_pcs;
            regw_p1    <= bus.d_regw;
            memw_p1    <= bus.d_memw;
            nowrite_p1 <= bus.d_nowrite;
        end
    end

    assign pass    = cond_pass(cond_p1, flags_q);
    assign cond_ex = vld_p1 & pass;
    // A held or killed instruction must not commit flags.
    assign flag_we = cond_ex & ~bus.stall & ~bus.flush;

    always_comb begin
        flags_next = flags_q;
        if (flag_we && flagw_p1[1]) flags_next[3:2] = bus.alu_flags[3:2];
        if (flag_we && flagw_p1[0]) flags_next[1:0] = bus.alu_flags[1:0];
    end

`ifdef COND_FLAG_SAVE_EN
    logic [3:0] shadow_q;

    // Save samples pre-edge flags, so save+restore together swaps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q  <= FLAGS_RESET;
            shadow_q <= FLAGS_RESET;
        end else begin
            if (bus.flag_save) shadow_q <= flags_q;
            if (bus.flag_restore) flags_q <= shadow_q;
            else flags_q <= flags_next;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flags_q <= FLAGS_RESET;
        else flags_q <= flags_next;
    end
`endif

    // Execute-stage outputs
    assign bus.flags    = flags_q;
    assign bus.e_valid  = vld_p1;
    assign bus.cond_ex  = cond_ex;
    assign bus.pcsrc    = cond_ex & pcs_p1;
    assign bus.regwrite = cond_ex & regw_p1 & ~nowrite_p1;
    assign bus.memwrite = cond_ex & memw_p1;

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-stage condition unit. It consumes the 4-bit NZCV flag vector produced by the 32-bit ALU and owns the architectural flag register.
- Captures per-instruction control from decode, evaluates the 4-bit condition field against the stored flags, gates the instruction's side effects, and conditionally writes the new ALU flags back.
- Sits between the decode pipeline register and the write-back/PC-select logic.

Parameters:
- FLAGS_RESET, 4'b0000, value loaded into the NZCV register on reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- d_valid  input  1  decode stage holds a valid instruction
- d_cond  input  4  condition field, Instr[31:28]
- d_flagw  input  2  flag write: [1]=update N,Z; [0]=update C,V
- d_pcs  input  1  instruction writes PC
- d_regw  input  1  instruction writes a register
- d_memw  input  1  instruction writes memory
- d_nowrite  input  1  compare-type instruction: suppress register write
- stall  input  1  hold the execute stage
- flush  input  1  kill the execute-stage instruction
- alu_flags  input  4  ALU flags of the execute-stage instruction: [3]=N [2]=Z [1]=C [0]=V
- flags  output  4  current architectural NZCV register
- cond_ex  output  1  condition passed for a valid execute-stage instruction
- pcsrc  output  1  gated PC write
- regwrite  output  1  gated register write
- memwrite  output  1  gated memory write
- e_valid  output  1  execute stage occupied

Behaviour:
- Reset (reset=0, asynchronous):
  - flags=FLAGS_RESET.
  - e_valid=0.
  - Captured control registers cleared to 0.
  - All outputs therefore 0, except flags=FLAGS_RESET.
- Stage load at rising clk, in priority order:
  - flush=1: e_valid<=0 (overrides stall).
  - else stall=1: hold all stage registers.
  - else: e_valid<=d_valid and capture d_cond, d_flagw, d_pcs, d_regw, d_memw, d_nowrite.
- Condition evaluation is combinational, using the registered flags only (not alu_flags):
  - EQ 0000: Z; NE 0001: !Z; CS 0010: C; CC 0011: !C
  - MI 0100: N; PL 0101: !N; VS 0110: V; VC 0111: !V
  - HI 1000: C&!Z; LS 1001: !C|Z
  - GE 1010: N==V; LT 1011: N!=V
  - GT 1100: !Z&(N==V); LE 1101: Z|(N!=V)
  - AL 1110: 1; 1111: 1
- Output gating:
  - cond_ex = e_valid & pass.
  - pcsrc = cond_ex & pcs.
  - regwrite = cond_ex & regw & !nowrite.
  - memwrite = cond_ex & memw.
  - Latency: outputs are valid in the cycle after the instruction is captured from decode.
- Flag write at rising clk when cond_ex=1, stall=0 and flush=0:
  - flagw[1] → flags[3:2] <= alu_flags[3:2].
  - flagw[0] → flags[1:0] <= alu_flags[1:0].
  - Halves are independent.
  - A stalled or flushed instruction never writes flags.
  - Stalled outputs stay asserted, but no flag write occurs until the stall releases.
- Back-to-back: the instruction following a flag-setting instruction sees the updated flags in its own execute cycle. No bypass is required.
- Failed condition: no outputs asserted, flags unchanged, and the stage still advances normally.
- Reset mid-operation: the instruction is lost, flags return to FLAGS_RESET, and no partial flag update occurs.

Optional Feature:
- Macro: COND_FLAG_SAVE_EN.
- When defined, adds inputs flag_save (1) and flag_restore (1) and a 4-bit shadow register, reset to FLAGS_RESET.
  - flag_save: shadow <= flags, taken at the same edge before any update.
  - flag_restore: flags <= shadow; overrides any ALU flag write in that cycle.
  - save and restore together: swap.
- When undefined: no extra ports, no shadow register.

Test Plan:
- Reset then EQ test: flags=0000, d_cond=0000 valid → cond_ex=0, regwrite=0. Then a SUB with flagw=11, alu_flags=0100 → flags=0100 next cycle, and a following EQ regwrite instruction asserts regwrite=1.
- Partial write: flags=1010, flagw=10, alu_flags=0101 → flags=0110 (C,V kept).
- Signed conditions: flags N=1,V=0 → GE gives 0, LT gives 1, LE gives 1. Flags N=1,V=1,Z=0 → GT gives 1.
- Compare/no-write: d_cond=1110, regw=1, nowrite=1, flagw=11 → regwrite=0 and flags updated from alu_flags.
- Stall/flush: a flag-setting instruction held by stall for 3 cycles → flags unchanged until release, then updated once. flush asserted together with stall → e_valid=0 next cycle, no flag write, pcsrc=0.
- Async reset mid-instruction with flags=1111 → flags=0000 and e_valid=0 immediately, without waiting for clk. With COND_FLAG_SAVE_EN: save at 1001, overwrite to 0000, restore → 1001.
